// File: rtl/regfile_write_scheduler_if.sv
// Bundle for the regfile write scheduler: requester, reservation,
// register-file write port and hazard-check signals.
interface regfile_write_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic                  rsv_valid;
  logic [ADDR_WIDTH-1:0] rsv_dest;
  logic                  rsv_ready;

  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_dest;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_ready;

  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_dest;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_ready;

  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_dest;
  logic [DATA_WIDTH-1:0] rf_data;

  logic [ADDR_WIDTH-1:0] chk_src_one;
  logic [ADDR_WIDTH-1:0] chk_src_two;
  logic                  hazard_one;
  logic                  hazard_two;

  logic [NUM_REGS-1:0]   busy;
  logic                  err_unreserved;

  modport master (
    output rsv_valid, rsv_dest,
    input  rsv_ready,
    output a_valid, a_dest, a_data,
    input  a_ready,
    output b_valid, b_dest, b_data,
    input  b_ready,
    input  rf_we, rf_dest, rf_data,
    output chk_src_one, chk_src_two,
    input  hazard_one, hazard_two,
    input  busy, err_unreserved
  );

  modport slave (
    input  rsv_valid, rsv_dest,
    output rsv_ready,
    input  a_valid, a_dest, a_data,
    output a_ready,
    input  b_valid, b_dest, b_data,
    output b_ready,
    output rf_we, rf_dest, rf_data,
    input  chk_src_one, chk_src_two,
    output hazard_one, hazard_two,
    output busy, err_unreserved
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Round-robin write-port scheduler plus busy scoreboard for the RF.
// Ports: clk, reset (sync, active-low), bus (slave side of the _if).
module regfile_write_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input logic clk,
  input logic reset,
  regfile_write_scheduler_if.slave bus
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  // 1 = requester B was granted most recently
  logic                  last_b_q, last_b_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_dest_q, rf_dest_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  gnt_a, gnt_b;
  logic                  rsv_acc, wr_acc;
  logic [ADDR_WIDTH-1:0] wr_dest;
  logic [DATA_WIDTH-1:0] wr_data;

  always_comb begin
    gnt_a = bus.a_valid & (~bus.b_valid | last_b_q);
    gnt_b = bus.b_valid & (~bus.a_valid | ~last_b_q);
  end

  always_comb begin
    bus.a_ready    = reset & gnt_a;
    bus.b_ready    = reset & gnt_b;
    bus.rsv_ready  = reset & ~busy_q[bus.rsv_dest];
    bus.hazard_one = busy_q[bus.chk_src_one];
    bus.hazard_two = busy_q[bus.chk_src_two];
    bus.busy       = busy_q;
    bus.err_unreserved = err_q;
    bus.rf_we      = rf_we_q;
    bus.rf_dest    = rf_dest_q;
    bus.rf_data    = rf_data_q;
  end

  always_comb begin
    rsv_acc = bus.rsv_valid & bus.rsv_ready;
    wr_acc  = bus.a_ready | bus.b_ready;
    wr_dest = bus.b_ready ? bus.b_dest : bus.a_dest;
    wr_data = bus.b_ready ? bus.b_data : bus.a_data;
  end

  always_comb begin
    last_b_d  = last_b_q;
    if (bus.a_ready) last_b_d = 1'b0;
    if (bus.b_ready) last_b_d = 1'b1;

    rf_we_d   = wr_acc;
    rf_dest_d = wr_acc ? wr_dest : rf_dest_q;
    rf_data_d = wr_acc ? wr_data : rf_data_q;

    // Clear and set never hit the same index: reserve needs ~busy.
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_dest_q] = 1'b0;
    if (rsv_acc) busy_d[bus.rsv_dest] = 1'b1;

    err_d = err_q | (wr_acc & ~busy_q[wr_dest]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_b_q  <= 1'b1;
      rf_we_q   <= 1'b0;
      rf_dest_q <= '0;
      rf_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      last_b_q  <= last_b_d;
      rf_we_q   <= rf_we_d;
      rf_dest_q <= rf_dest_d;
      rf_data_q <= rf_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end
endmodule
